// File: rtl/bank_rr_arbiter.sv
// Per-bank round-robin arbiter: picks one FIFO request per cycle and forwards its payload; `ARB_FIXED_PRIO_EN` selects fixed lowest-index priority.
// Latency: one cycle from req sample to registered gnt/bank_wr_en/bank_wr_data/bank_src_id.
// Backpressure: bank_ready=0 suppresses the grant and freezes the priority pointer and output payload.
module bank_rr_arbiter #(
  parameter int REQ_NUM    = 16,
  parameter int FIFO_WIDTH = 36,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = $clog2(REQ_NUM),
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_NUM-1:0]            req,
  input  logic [REQ_NUM*FIFO_WIDTH-1:0] req_data,
  input  logic                          bank_ready,
  output logic [REQ_NUM-1:0]            gnt,
  output logic                          bank_wr_en,
  output logic [DATA_WIDTH-1:0]         bank_wr_data,
  output logic [ID_W-1:0]               bank_src_id,
  output logic [CNT_W-1:0]              conflict_cnt,
  input  logic                          clr_cnt
);

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       cand;
  logic                  win_vld;
  logic                  arb_vld;
  logic                  multi_req;
  logic [REQ_NUM-1:0]    win_oh;
  logic [DATA_WIDTH-1:0] win_dat;

  // Scan from ptr upward; ID_W-bit addition wraps modulo REQ_NUM.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = ptr + ID_W'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    win_dat         = req_data[int'(win_idx)*FIFO_WIDTH +: DATA_WIDTH];
  end

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_req = |(req & (req - REQ_NUM'(1)));
  assign arb_vld   = bank_ready && win_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= '0;
      bank_wr_en   <= 1'b0;
      bank_wr_data <= '0;
      bank_src_id  <= '0;
    end else if (arb_vld) begin
      gnt          <= win_oh;
      bank_wr_en   <= 1'b1;
      bank_wr_data <= win_dat;
      bank_src_id  <= win_idx;
    end else begin
      gnt          <= '0;
      bank_wr_en   <= 1'b0;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (arb_vld) begin
      ptr <= win_idx + ID_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (clr_cnt) begin
      conflict_cnt <= '0;
    end else if (bank_ready && multi_req && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/bank_rr_arbiter.md
# bank_rr_arbiter

Per-bank round-robin arbiter sitting directly downstream of the PEA-side request FIFOs. Each FIFO raises one request bit per memory bank. One arbiter instance per bank collects that bank's request column across all FIFOs, picks one winner per cycle, and returns a one-hot grant that feeds each FIFO's `nxt_gnt` bit for this bank. It also forwards the winner's payload to the bank write port and keeps a saturating conflict counter for profiling.

## Interface

Parameters:
- `REQ_NUM`, 16, number of requesting FIFOs (PEAs); power of two, ≥2
- `FIFO_WIDTH`, 36, width of one FIFO word: `[FIFO_WIDTH-1:DATA_WIDTH]` is the bank field, the rest is payload
- `DATA_WIDTH`, 32, payload width forwarded to the bank
- `ID_W`, 4, `$clog2(REQ_NUM)`, width of the source id
- `CNT_W`, 16, conflict counter width

Ports:
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `req` input REQ_NUM: request bit i comes from FIFO i (its `req_pea_to_bank[BANK]`)
- `req_data` input REQ_NUM*FIFO_WIDTH: FIFO i word at `[i*FIFO_WIDTH +: FIFO_WIDTH]`
- `bank_ready` input 1: bank can accept a write this cycle
- `gnt` output REQ_NUM: registered one-hot grant, drives each FIFO's `nxt_gnt[BANK]`
- `bank_wr_en` output 1: registered write strobe to the bank
- `bank_wr_data` output DATA_WIDTH: registered winner payload
- `bank_src_id` output ID_W: registered index of the winner
- `conflict_cnt` output CNT_W: saturating count of contested cycles
- `clr_cnt` input 1: synchronous clear of `conflict_cnt`

## Operation

- State: priority pointer `ptr` (ID_W bits, the index of the highest-priority requester), output registers, and `conflict_cnt`.
- Each cycle, if `bank_ready`=1 and `req`≠0, the winner is the first asserted `req[j]`, scanning j = ptr, ptr+1, … modulo REQ_NUM. On the next edge:
  - `gnt` ← one-hot(j)
  - `bank_wr_en` ← 1
  - `bank_wr_data` ← `req_data[j*FIFO_WIDTH +: DATA_WIDTH]`, so the bank field is stripped
  - `bank_src_id` ← j
  - `ptr` ← (j+1) mod REQ_NUM; wrap 15→0 at the default width
- If `bank_ready`=0 or `req`=0: `gnt` ← 0, `bank_wr_en` ← 0, `bank_wr_data` and `bank_src_id` hold, `ptr` holds.
- A grant is a single-cycle pulse. A requester that keeps `req` high is re-arbitrated every cycle and may win back-to-back only if no other requester is asserted.
- `conflict_cnt`:
  - Increments when `bank_ready`=1 and popcount(`req`) ≥ 2.
  - Saturates at 2^CNT_W−1.
  - `clr_cnt`=1 forces it to 0 on the next edge, taking precedence over increment.
- Grant never asserts for a requester whose `req` bit was 0 in the sampled cycle.
- At most one `gnt` bit is high at any time.

## Timing

- Latency: `req` sampled at edge t produces `gnt`, `bank_wr_en` and data at edge t+1, valid during cycle t+1.
- `bank_ready` is sampled in the same cycle as `req`. Deasserting it at cycle t suppresses the grant at t+1 and leaves the priority unchanged.
- Reset (asynchronous, immediate, including mid-operation):
  - `gnt`=0, `bank_wr_en`=0, `bank_wr_data`=0, `bank_src_id`=0
  - `conflict_cnt`=0, `ptr`=0, so requester 0 has the highest priority
- First edge after `rst_n` rises arbitrates normally.

## Configuration

- `ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest asserted index always wins, and `ptr` is held at 0 and never updated. All other behaviour is unchanged.
  - Undefined (default): round-robin as described above.

## Test plan

- Reset then idle: `req`=0, `bank_ready`=1 for 5 cycles → `gnt`=0, `bank_wr_en`=0, `conflict_cnt`=0 throughout.
- Single requester: `req`=16'h0020, `req_data[5]`=36'h3_DEADBEEF for 3 cycles → `gnt`=16'h0020 in each of the next 3 cycles; `bank_wr_data`=32'hDEADBEEF; `bank_src_id`=5; `conflict_cnt`=0.
- Full contention: `req`=16'hFFFF held for 18 cycles after reset → grants in order 0,1,…,15,0,1 (wrap verified); `conflict_cnt`=18.
- Fairness and pointer: grant to 3, then `req`=16'h0009 → next grant goes to 0 (the scan wraps from ptr=4), then 3.
- Stall: `req`=16'h0003 with `bank_ready`=0 for 2 cycles, then 1 → no grant during the stall and no counter increment; the first grant after the stall goes to requester 0.
- Async reset mid-grant: assert `rst_n`=0 between edges while `gnt` is high → `gnt`, `bank_wr_en` and `conflict_cnt` drop to 0 immediately. With `ARB_FIXED_PRIO_EN`, `req`=16'hFFFF always grants 0.
